// File: rtl/deint_pkg.sv
// Shared constants for the convolutional deinterleaver: branch count, branch
// index width, MPEG-TS sync byte and a branch-index to one-hot helper.
package deint_pkg;

  localparam int NUM_BR = 12;
  localparam int BR_W = 4;
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  // Out-of-range indices (12..15) map to an all-zero vector.
  function automatic logic [NUM_BR-1:0] br_onehot(input logic [BR_W-1:0] br);
    logic [NUM_BR-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      oh[i] = (br == BR_W'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/br_counter.sv
// Modulo-NUM_BR branch counter shared by the write- and read-side commutators.
// load0 marks the current item as branch 0, so with inc the next count is 1.
module br_counter
  import deint_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load0,
  output logic [BR_W-1:0] count
);

  logic [BR_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (count >= BR_W'(NUM_BR)) begin
      // Unreachable encodings recover to branch 0.
      count_nxt = '0;
    end else if (inc) begin
      if (load0) begin
        count_nxt = BR_W'(1);
      end else if (count == BR_W'(NUM_BR - 1)) begin
        count_nxt = '0;
      end else begin
        count_nxt = count + BR_W'(1);
      end
    end else if (load0) begin
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/deint_commutator.sv
// Deinterleaver input commutator: round-robin distribution of a byte stream
// over NUM_BR branch FIFOs. Build option: SYNC_ALIGN_EN (realign on in_sync).
module deint_commutator
  import deint_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sync,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_BR-1:0] out_valid,
  input  logic [NUM_BR-1:0] out_ready,
  output logic [BR_W-1:0]   cur_branch,
  output logic              sync_err
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; valid never depends on ready, and a held valid keeps its data stable.
  // The output stage is one register whose one-hot valid selects the single
  // branch ready that matters; that ready passes straight to in_ready so a
  // byte can leave and be replaced in the same cycle.
  logic              in_acc;
  logic              out_acc;
  logic              sync_hit;
  logic [BR_W-1:0]   tgt_br;

  assign out_acc  = |(out_valid & out_ready);
  assign in_ready = ~(|out_valid) | out_acc;
  assign in_acc   = in_valid & in_ready;

`ifdef SYNC_ALIGN_EN
  assign sync_hit = in_acc & in_sync;
`else
  logic unused_sync;
  assign unused_sync = in_sync;
  assign sync_hit    = 1'b0;
`endif

  assign tgt_br = sync_hit ? '0 : cur_branch;

  br_counter u_br_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_acc),
    .load0 (sync_hit),
    .count (cur_branch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= '0;
    end else if (in_acc) begin
      out_data  <= in_data;
      out_valid <= br_onehot(tgt_br);
    end else if (out_acc) begin
      out_valid <= '0;
    end
  end

`ifdef SYNC_ALIGN_EN
  // Pulse coincides with the first cycle of out_valid for the realigned byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= sync_hit && (cur_branch != '0);
    end
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_deint_commutator.sv
// Self-checking bench for deint_commutator: directed scenarios plus random
// traffic against a round-robin reference model and an expected-byte queue.
module tb_deint_commutator;
  import deint_pkg::*;

  localparam int DW = 8;
  localparam int W  = BR_W + DW;
`ifdef SYNC_ALIGN_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_sync = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     out_data;
  logic [NUM_BR-1:0] out_valid;
  logic [NUM_BR-1:0] out_ready = '1;
  logic [BR_W-1:0]   cur_branch;
  logic              sync_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one pending byte plus the count of the next branch.
  bit            m_pend;
  logic [DW-1:0] m_data;
  int            m_br;
  int            m_next;
  bit            m_serr;
  logic [W-1:0]  exp_q[$];

  deint_commutator #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sync    (in_sync),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cur_branch (cur_branch),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = 1'b0;
    m_data = '0;
    m_br   = 0;
    m_next = 0;
    m_serr = 1'b0;
    exp_q.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_sync = 1'b0;
    out_ready = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; checks in_ready and any delivery before the edge,
  // then the full output state after it.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit s,
                      input logic [NUM_BR-1:0] rdy);
    bit exp_rdy, acc, oacc;
    int tgt;
    logic [W-1:0] e;
    logic [NUM_BR-1:0] exp_ov;
    @(negedge clk);
    in_valid = v; in_data = d; in_sync = s; out_ready = rdy;
    #1;
    exp_rdy = !m_pend || rdy[m_br];
    n_checks++;
    if (in_ready !== exp_rdy)
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
    else n_pass++;
    oacc = m_pend && rdy[m_br];
    if (oacc) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL delivery: byte %h on %h with nothing expected", out_data, out_valid);
      end else begin
        e = exp_q.pop_front();
        if ({out_valid, out_data} !== {(NUM_BR'(1) << e[W-1:DW]), e[DW-1:0]})
          $display("FAIL delivery: got valid %h data %h expected branch %0d data %h",
                   out_valid, out_data, e[W-1:DW], e[DW-1:0]);
        else n_pass++;
      end
    end
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    if (acc) begin
      tgt    = (SYNC && s) ? 0 : m_next;
      m_serr = SYNC && s && (m_next != 0);
      m_pend = 1'b1;
      m_data = d;
      m_br   = tgt;
      m_next = (tgt + 1) % NUM_BR;
      exp_q.push_back({BR_W'(tgt), d});
    end else begin
      m_serr = 1'b0;
      if (oacc) m_pend = 1'b0;
    end
    exp_ov = m_pend ? (NUM_BR'(1) << m_br) : '0;
    n_checks++;
    if ({out_valid, out_data, cur_branch, sync_err} !== {exp_ov, m_data, BR_W'(m_next), m_serr})
      $display("FAIL outputs: got valid %h data %h br %0d serr %b expected valid %h data %h br %0d serr %b",
               out_valid, out_data, cur_branch, sync_err, exp_ov, m_data, m_next, m_serr);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_checks++;
    if ({out_valid, out_data, cur_branch, sync_err, in_ready} !== {{NUM_BR{1'b0}}, 8'h00, 4'd0, 1'b0, 1'b1})
      $display("FAIL reset_values: got valid %h data %h br %0d serr %b rdy %b expected 0/0/0/0/1",
               out_valid, out_data, cur_branch, sync_err, in_ready);
    else n_pass++;
  endtask

  task automatic test_stream();
    reset_dut();
    for (int k = 0; k < 24; k++) step(1'b1, DW'(k), 1'b0, '1);
    n_checks++;
    if (out_valid !== NUM_BR'(1 << 11) || out_data !== 8'h17)
      $display("FAIL stream_last: got valid %h data %h expected 800 17", out_valid, out_data);
    else n_pass++;
    step(1'b0, 8'h00, 1'b0, '1);
  endtask

  task automatic test_backpressure();
    logic [NUM_BR-1:0] hold;
    hold = ~(NUM_BR'(1) << 3);
    reset_dut();
    for (int k = 0; k < 4; k++) step(1'b1, 8'hA0 + DW'(k), 1'b0, '1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'hA4, 1'b0, hold);
      n_checks++;
      if (out_data !== 8'hA3 || out_valid !== NUM_BR'(1 << 3))
        $display("FAIL stall_hold: got data %h valid %h expected a3 008", out_data, out_valid);
      else n_pass++;
    end
    for (int k = 4; k < 8; k++) step(1'b1, 8'hA0 + DW'(k), 1'b0, '1);
    step(1'b0, 8'h00, 1'b0, '1);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL bp_drain: got %0d undelivered bytes expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_gaps();
    reset_dut();
    for (int k = 0; k < 10; k++) step(k % 2 == 0, 8'h30 + DW'(k), 1'b0, '1);
    n_checks++;
    if (cur_branch !== 4'd5)
      $display("FAIL gaps_count: got %0d expected 5", cur_branch);
    else n_pass++;
  endtask

  task automatic test_midreset();
    reset_dut();
    for (int k = 0; k < 7; k++) step(1'b1, 8'h60 + DW'(k), 1'b0, '1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== '0 || cur_branch !== 4'd0)
      $display("FAIL async_reset: got valid %h br %0d expected 0 0", out_valid, cur_branch);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 8'h99, 1'b0, '1);
    n_checks++;
    if (out_valid !== NUM_BR'(1) || out_data !== 8'h99)
      $display("FAIL post_reset_branch: got valid %h data %h expected 001 99", out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_sync();
    reset_dut();
    for (int k = 0; k < 5; k++) step(1'b1, 8'h10 + DW'(k), 1'b0, '1);
    step(1'b1, SYNC_BYTE, 1'b1, '1);
    n_checks++;
    if (out_valid !== (SYNC ? NUM_BR'(1) : NUM_BR'(1 << 5)) || sync_err !== SYNC)
      $display("FAIL sync_misaligned: got valid %h serr %b expected valid %h serr %b",
               out_valid, sync_err, SYNC ? NUM_BR'(1) : NUM_BR'(1 << 5), SYNC);
    else n_pass++;
    step(1'b1, 8'h20, 1'b0, '1);
    n_checks++;
    if (out_valid !== (SYNC ? NUM_BR'(1 << 1) : NUM_BR'(1 << 6)) || sync_err !== 1'b0)
      $display("FAIL sync_next: got valid %h serr %b", out_valid, sync_err);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, '1);
    reset_dut();
    step(1'b1, SYNC_BYTE, 1'b1, '1);
    n_checks++;
    if (out_valid !== NUM_BR'(1) || sync_err !== 1'b0)
      $display("FAIL sync_aligned: got valid %h serr %b expected 001 0", out_valid, sync_err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NUM_BR-1:0] rdy;
    reset_dut();
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < NUM_BR; b++) rdy[b] = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 9) == 0, rdy);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0, '1);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL random_drain: got %0d undelivered bytes expected 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_gaps();
    test_midreset();
    test_sync();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
